// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, decode enums and the registered control bundle type
//   Shared by decode_stage and decode_regfile.
package decode_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    // Three bits cannot name all ten RV32I ALU operations: unsigned compare
    // shares SLT and arithmetic right shift shares SR.
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SR
    } alu_ctrl_e;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;
    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4, RES_IMM} result_src_e;
    typedef struct packed {
        alu_ctrl_e   alu_ctrl;
        logic        alu_src;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        logic        jump;
        logic        branch_neg;
        logic        pc_op;
        logic        reg_write;
        logic        illegal;
    } ctrl_t;
    function automatic alu_ctrl_e alu_from_f3(input logic [2:0] f3, input logic sub);
        return f3 == 3'd0 ? (sub ? ALU_SUB : ALU_ADD) :
               f3 == 3'd1 ? ALU_SLL :
               f3 == 3'd2 || f3 == 3'd3 ? ALU_SLT :
               f3 == 3'd4 ? ALU_XOR :
               f3 == 3'd5 ? ALU_SR :
               f3 == 3'd6 ? ALU_OR : ALU_AND;
    endfunction
endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: 2R1W register file, x0 hardwired to zero, a0 debug tap
//   clk/rst      clock, synchronous active-high reset (clears every register)
//   we/waddr/wdata  write port
//   raddr1/2 -> rdata1/2  read ports; a0  live contents of register 10
//   DECODE_BYPASS_EN defined: a read of the register being written returns wdata
module decode_regfile import decode_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic [DATA_WIDTH-1:0] a0
);
    localparam int N = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] r_regs [N];
    logic                  w_we;
    assign w_we = we && waddr != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[waddr] <= wdata;
        end
    end
`ifdef DECODE_BYPASS_EN
    assign rdata1 = raddr1 == '0 ? '0 : (w_we && waddr == raddr1) ? wdata : r_regs[raddr1];
    assign rdata2 = raddr2 == '0 ? '0 : (w_we && waddr == raddr2) ? wdata : r_regs[raddr2];
`else
    assign rdata1 = raddr1 == '0 ? '0 : r_regs[raddr1];
    assign rdata2 = raddr2 == '0 ? '0 : r_regs[raddr2];
`endif
    assign a0 = r_regs[10];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with one-cycle valid/ready pipeline register
//   clk/rst            clock, synchronous active-high reset
//   in_valid/in_ready, instr, pc      upstream handshake and instruction
//   wb_en/wb_rd/wb_data               register writeback
//   flush                             drop held and incoming instruction
//   out_valid/out_ready + bundle      decoded control, register indices,
//                                     operands, immediate and pc
//   a0                                register 10, debug
//   DECODE_BYPASS_EN selects write-to-read bypass in the register file
module decode_stage import decode_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            alu_ctrl,
    output logic                  alu_src,
    output logic                  mem_write,
    output logic [1:0]            result_src,
    output logic                  branch,
    output logic                  jump,
    output logic                  branch_neg,
    output logic                  pc_op,
    output logic                  reg_write,
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] rd,
    output logic [ADDR_WIDTH-1:0] rs1,
    output logic [ADDR_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic [DATA_WIDTH-1:0] imm_ext,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] a0
);
    logic [6:0]            w_op;
    logic [2:0]            w_f3;
    logic [ADDR_WIDTH-1:0] w_rd, w_rs1, w_rs2;
    logic [DATA_WIDTH-1:0] w_rd1, w_rd2, w_imm;
    logic [31:0]           w_imm32;
    imm_src_e              w_imm_src;
    ctrl_t                 w_ctrl;
    logic                  w_in_fire, w_stall;
    logic                  r_valid;
    ctrl_t                 r_ctrl;
    logic [ADDR_WIDTH-1:0] r_rd, r_rs1, r_rs2;
    logic [DATA_WIDTH-1:0] r_rd1, r_rd2, r_imm, r_pc;
    assign w_op  = instr[6:0];
    assign w_f3  = instr[14:12];
    assign w_rd  = instr[7 +: ADDR_WIDTH];
    assign w_rs1 = instr[15 +: ADDR_WIDTH];
    assign w_rs2 = instr[20 +: ADDR_WIDTH];
    decode_regfile #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_regfile (
        .clk(clk), .rst(rst), .we(wb_en), .waddr(wb_rd), .wdata(wb_data),
        .raddr1(w_rs1), .raddr2(w_rs2), .rdata1(w_rd1), .rdata2(w_rd2), .a0(a0)
    );
    always_comb begin
        w_ctrl    = '0;
        w_imm_src = IMM_I;
        case (w_op)
            OP_LUI: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.result_src = RES_IMM;
                w_imm_src         = IMM_U;
            end
            OP_AUIPC: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.pc_op     = 1'b1;
                w_imm_src        = IMM_U;
            end
            OP_JAL: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.jump       = 1'b1;
                w_ctrl.pc_op      = 1'b1;
                w_ctrl.result_src = RES_PC4;
                w_imm_src         = IMM_J;
            end
            OP_JALR: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.jump       = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.result_src = RES_PC4;
            end
            OP_BRANCH: begin
                // funct3 bit 0 marks the inverted sense: bne, bge, bgeu
                w_ctrl.branch     = 1'b1;
                w_ctrl.branch_neg = w_f3[0];
                w_ctrl.alu_ctrl   = w_f3[2] ? ALU_SLT : ALU_SUB;
                w_imm_src         = IMM_B;
            end
            OP_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_imm_src        = IMM_S;
            end
            OP_IMM: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_ctrl  = alu_from_f3(w_f3, 1'b0);
            end
            OP_OP: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_ctrl  = alu_from_f3(w_f3, instr[30]);
            end
            default: w_ctrl.illegal = 1'b1;
        endcase
    end
    assign w_imm32 =
        w_imm_src == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
        w_imm_src == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
        w_imm_src == IMM_U ? {instr[31:12], 12'b0} :
        w_imm_src == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                             {{20{instr[31]}}, instr[31:20]};
    assign w_imm     = DATA_WIDTH'($signed(w_imm32));
    assign in_ready  = !r_valid || out_ready;
    assign w_in_fire = in_valid && in_ready;
    assign w_stall   = r_valid && !out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_rd    <= w_rd;
            r_rs1   <= w_rs1;
            r_rs2   <= w_rs2;
            r_rd1   <= w_rd1;
            r_rd2   <= w_rd2;
            r_imm   <= w_imm;
            r_pc    <= pc;
        end else begin
            r_valid <= w_stall;
            // keep held operands coherent with writebacks that land during a stall
            if (w_stall && wb_en && r_rs1 != '0 && wb_rd == r_rs1) r_rd1 <= wb_data;
            if (w_stall && wb_en && r_rs2 != '0 && wb_rd == r_rs2) r_rd2 <= wb_data;
        end
    end
    assign out_valid  = r_valid;
    assign alu_ctrl   = r_ctrl.alu_ctrl;
    assign alu_src    = r_ctrl.alu_src;
    assign mem_write  = r_ctrl.mem_write;
    assign result_src = r_ctrl.result_src;
    assign branch     = r_ctrl.branch;
    assign jump       = r_ctrl.jump;
    assign branch_neg = r_ctrl.branch_neg;
    assign pc_op      = r_ctrl.pc_op;
    assign reg_write  = r_ctrl.reg_write;
    assign illegal    = r_ctrl.illegal;
    assign rd         = r_rd;
    assign rs1        = r_rs1;
    assign rs2        = r_rs2;
    assign rd1        = r_rd1;
    assign rd2        = r_rd2;
    assign imm_ext    = r_imm;
    assign pc_out     = r_pc;
endmodule
